l1_d_data_array_nway: RTL and testbench



---
 rtl/l1_d_data_array_nway.sv | 184 ++++++++++++++++++
 tb/tb_l1_d_data_array_nway.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_d_data_array_nway.sv
// rtl/l1_d_data_array_nway.sv - N-way L1 D-cache data array with CPU word access, multi-beat refill and evict
module l1_d_data_array_nway #(
    parameter int WAYS      = 2,
    parameter int INUM      = 5,
    parameter int LINE_BITS = 512,
    parameter int WORD_BITS = 32,
    parameter int BEAT_BITS = 128,
    localparam int WBITS    = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int OFFBITS  = $clog2(LINE_BITS / 8),
    localparam int NBE      = WORD_BITS / 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [INUM-1:0]      i_index,
    input  logic [OFFBITS-1:0]   i_offset,
    input  logic [WBITS-1:0]     i_way,
    input  logic                 i_rd_en,
    input  logic                 i_wr_en,
    input  logic [WORD_BITS-1:0] i_wr_data,
    input  logic [NBE-1:0]       i_wr_be,
    output logic [WORD_BITS-1:0] o_rd_data,
    output logic                 o_rd_valid,
    input  logic                 i_refill_start,
    input  logic                 i_refill_valid,
    input  logic [BEAT_BITS-1:0] i_refill_data,
    output logic                 o_refill_ready,
    output logic                 o_refill_done,
    input  logic                 i_evict_start,
    output logic                 o_evict_valid,
    output logic [BEAT_BITS-1:0] o_evict_data,
    input  logic                 i_evict_ready,
    output logic                 o_evict_done,
    output logic                 o_busy
);

    localparam int SETS  = 1 << INUM;
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int WSEL  = $clog2(NBE);
    localparam int LB    = $clog2(LINE_BITS);
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_EVICT
    } state_t;

    // Line storage; deliberately not reset, contents are undefined until written.
    logic [LINE_BITS-1:0] r_mem [SETS][WAYS];

    state_t               r_state;
    logic [INUM-1:0]      r_idx;
    logic [WBITS-1:0]     r_way;
    logic [BCW-1:0]       r_beat;
    logic [WORD_BITS-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic                 r_refill_ready;
    logic                 r_refill_done;
    logic                 r_evict_valid;
    logic [BEAT_BITS-1:0] r_evict_data;
    logic                 r_evict_done;
    logic                 r_busy;

    logic [OFFBITS-WSEL-1:0] w_word;
    logic [LB-1:0]           w_word_base;
    logic [LB-1:0]           w_beat_base;
    logic [BCW-1:0]          w_next_beat;
    logic [LB-1:0]           w_next_base;
    logic                    w_last_beat;
    logic [WORD_BITS-1:0]    w_rd_word;
    logic                    w_idle;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_word      = i_offset[OFFBITS-1:WSEL];
    assign w_word_base = LB'(w_word) << $clog2(WORD_BITS);
    assign w_beat_base = LB'(r_beat) << $clog2(BEAT_BITS);
    assign w_next_beat = r_beat + BCW'(1);
    assign w_next_base = LB'(w_next_beat) << $clog2(BEAT_BITS);
    assign w_last_beat = (r_beat == BCW'(BEATS - 1));
    assign w_rd_word   = r_mem[i_index][i_way][w_word_base +: WORD_BITS];

    // Array writes: byte-enabled CPU word in IDLE, one refill beat per accepted handshake.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_idle && i_wr_en) begin
                for (int b = 0; b < NBE; b++) begin
                    if (i_wr_be[b]) begin
                        r_mem[i_index][i_way][w_word_base + LB'(8 * b) +: 8] <= i_wr_data[8 * b +: 8];
                    end
                end
            end else if (r_state == ST_REFILL && i_refill_valid) begin
                r_mem[r_idx][r_way][w_beat_base +: BEAT_BITS] <= i_refill_data;
            end
        end
    end

    // Control FSM with registered outputs: CPU reads, refill beat counting, evict beat streaming.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_way          <= '0;
            r_beat         <= '0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_refill_ready <= 1'b0;
            r_refill_done  <= 1'b0;
            r_evict_valid  <= 1'b0;
            r_evict_data   <= '0;
            r_evict_done   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_rd_valid    <= 1'b0;
            r_refill_done <= 1'b0;
            r_evict_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Read samples the array before this edge's write lands, so a same-word
                    // read and write in one cycle returns the old data.
                    if (i_rd_en) begin
                        r_rd_data  <= w_rd_word;
                        r_rd_valid <= 1'b1;
                    end
                    if (i_evict_start) begin
                        r_state       <= ST_EVICT;
                        r_idx         <= i_index;
                        r_way         <= i_way;
                        r_beat        <= '0;
                        r_evict_valid <= 1'b1;
                        r_evict_data  <= r_mem[i_index][i_way][BEAT_BITS-1:0];
                        r_busy        <= 1'b1;
                    end else if (i_refill_start) begin
                        r_state        <= ST_REFILL;
                        r_idx          <= i_index;
                        r_way          <= i_way;
                        r_beat         <= '0;
                        r_refill_ready <= 1'b1;
                        r_busy         <= 1'b1;
                    end
                end
                ST_REFILL: begin
                    if (i_refill_valid) begin
                        if (w_last_beat) begin
                            r_state        <= ST_IDLE;
                            r_beat         <= '0;
                            r_refill_ready <= 1'b0;
                            r_refill_done  <= 1'b1;
                            r_busy         <= 1'b0;
                        end else begin
                            r_beat <= w_next_beat;
                        end
                    end
                end
                ST_EVICT: begin
                    if (i_evict_ready) begin
                        if (w_last_beat) begin
                            r_state       <= ST_IDLE;
                            r_beat        <= '0;
                            r_evict_valid <= 1'b0;
                            r_evict_done  <= 1'b1;
                            r_busy        <= 1'b0;
                        end else begin
                            r_beat       <= w_next_beat;
                            r_evict_data <= r_mem[r_idx][r_way][w_next_base +: BEAT_BITS];
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rd_data      = r_rd_data;
    assign o_rd_valid     = r_rd_valid;
    assign o_refill_ready = r_refill_ready;
    assign o_refill_done  = r_refill_done;
    assign o_evict_valid  = r_evict_valid;
    assign o_evict_data   = r_evict_data;
    assign o_evict_done   = r_evict_done;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_l1_d_data_array_nway.sv
// tb/tb_l1_d_data_array_nway.sv - self-checking bench for l1_d_data_array_nway
module tb_l1_d_data_array_nway;

    localparam int SETS  = 32;
    localparam int WORDS = 16;
    localparam int BEATS = 4;
    localparam int WPB   = 4;

    logic         clk;
    logic         rst;
    logic [4:0]   i_index;
    logic [5:0]   i_offset;
    logic [0:0]   i_way;
    logic         i_rd_en;
    logic         i_wr_en;
    logic [31:0]  i_wr_data;
    logic [3:0]   i_wr_be;
    logic [31:0]  o_rd_data;
    logic         o_rd_valid;
    logic         i_refill_start;
    logic         i_refill_valid;
    logic [127:0] i_refill_data;
    logic         o_refill_ready;
    logic         o_refill_done;
    logic         i_evict_start;
    logic         o_evict_valid;
    logic [127:0] o_evict_data;
    logic         i_evict_ready;
    logic         o_evict_done;
    logic         o_busy;

    l1_d_data_array_nway dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_index        (i_index),
        .i_offset       (i_offset),
        .i_way          (i_way),
        .i_rd_en        (i_rd_en),
        .i_wr_en        (i_wr_en),
        .i_wr_data      (i_wr_data),
        .i_wr_be        (i_wr_be),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .i_refill_start (i_refill_start),
        .i_refill_valid (i_refill_valid),
        .i_refill_data  (i_refill_data),
        .o_refill_ready (o_refill_ready),
        .o_refill_done  (o_refill_done),
        .i_evict_start  (i_evict_start),
        .o_evict_valid  (o_evict_valid),
        .o_evict_data   (o_evict_data),
        .i_evict_ready  (i_evict_ready),
        .o_evict_done   (o_evict_done),
        .o_busy         (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: words of every line, plus the words of a line about to be refilled.
    logic [31:0]  m_word [SETS][2][WORDS];
    logic [31:0]  new_words [WORDS];
    logic [127:0] cap [BEATS];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [5:0]  off;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          ev;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_beat(int idx, int way, int b);
        logic [127:0] r;
        for (int k = 0; k < WPB; k++) r[k*32 +: 32] = m_word[idx][way][b*WPB + k];
        return r;
    endfunction

    function automatic logic [127:0] nw_beat(int b);
        logic [127:0] r;
        for (int k = 0; k < WPB; k++) r[k*32 +: 32] = new_words[b*WPB + k];
        return r;
    endfunction

    task automatic model_write(int idx, int way, logic [5:0] off, logic [31:0] d, logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) m_word[idx][way][off >> 2][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic cpu_op(bit rd, bit wr, int idx, int way, logic [5:0] off, logic [31:0] d, logic [3:0] be);
        logic [31:0] exp;
        exp        = m_word[idx][way][off >> 2];
        i_index    = 5'(idx);
        i_way      = 1'(way);
        i_offset   = off;
        i_rd_en    = rd;
        i_wr_en    = wr;
        i_wr_data  = d;
        i_wr_be    = be;
        step();
        i_rd_en = 1'b0;
        i_wr_en = 1'b0;
        chk("cpu_rd_valid", o_rd_valid, rd);
        if (rd) chk("cpu_rd_data", o_rd_data, exp);
        if (wr) model_write(idx, way, off, d, be);
    endtask

    task automatic do_refill(int idx, int way, bit gaps);
        int b;
        int cyc;
        bit v;
        i_index        = 5'(idx);
        i_way          = 1'(way);
        i_refill_start = 1'b1;
        step();
        i_refill_start = 1'b0;
        chk("refill_busy", o_busy, 1'b1);
        b   = 0;
        cyc = 0;
        while (b < BEATS && cyc < 200) begin
            v              = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_refill_valid = v;
            i_refill_data  = v ? nw_beat(b) : 128'(~nw_beat(b));
            chk("refill_ready", o_refill_ready, 1'b1);
            chk("refill_done_early", o_refill_done, 1'b0);
            step();
            if (v) b++;
            cyc++;
        end
        i_refill_valid = 1'b0;
        chk("refill_beats_accepted", 32'(b), 32'(BEATS));
        chk("refill_done", o_refill_done, 1'b1);
        chk("refill_busy_clear", o_busy, 1'b0);
        chk("refill_ready_clear", o_refill_ready, 1'b0);
        for (int k = 0; k < WORDS; k++) m_word[idx][way][k] = new_words[k];
    endtask

    task automatic do_evict(int idx, int way, int stall, bit rand_rdy, bit both, bit poke);
        int b;
        int cyc;
        bit r;
        i_index        = 5'(idx);
        i_way          = 1'(way);
        i_evict_start  = 1'b1;
        i_refill_start = both;
        step();
        i_evict_start  = 1'b0;
        i_refill_start = 1'b0;
        chk("evict_busy", o_busy, 1'b1);
        if (both) chk("prio_refill_ready", o_refill_ready, 1'b0);
        b   = 0;
        cyc = 0;
        while (b < BEATS && cyc < 200) begin
            r             = (cyc < stall) ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            i_evict_ready = r;
            if (poke && cyc == 0) begin
                i_offset       = 6'h08;
                i_wr_en        = 1'b1;
                i_wr_data      = 32'hFFFF_FFFF;
                i_wr_be        = 4'hF;
                i_refill_valid = 1'b1;
                i_refill_data  = {4{32'hDEAD_BEEF}};
            end
            chk("evict_valid", o_evict_valid, 1'b1);
            chk("evict_data", o_evict_data, exp_beat(idx, way, b));
            if (both) chk("prio_no_refill", o_refill_ready, 1'b0);
            cap[b] = o_evict_data;
            step();
            i_wr_en        = 1'b0;
            i_refill_valid = 1'b0;
            if (r) b++;
            cyc++;
        end
        i_evict_ready = 1'b0;
        chk("evict_beats_accepted", 32'(b), 32'(BEATS));
        chk("evict_done", o_evict_done, 1'b1);
        chk("evict_busy_clear", o_busy, 1'b0);
        chk("evict_valid_clear", o_evict_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        i_index        = '0;
        i_offset       = '0;
        i_way          = '0;
        i_rd_en        = 1'b0;
        i_wr_en        = 1'b0;
        i_wr_data      = '0;
        i_wr_be        = '0;
        i_refill_start = 1'b0;
        i_refill_valid = 1'b0;
        i_refill_data  = '0;
        i_evict_start  = 1'b0;
        i_evict_ready  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_rd_valid", o_rd_valid, 1'b0);
        chk("rst_rd_data", o_rd_data, 32'h0);
        chk("rst_refill_ready", o_refill_ready, 1'b0);
        chk("rst_evict_valid", o_evict_valid, 1'b0);
        chk("rst_evict_data", o_evict_data, 128'h0);
        chk("rst_busy", o_busy, 1'b0);
        rst = 1'b0;
        step();

        // Refill set 5 way 1 with word k = 0x050100kk
        for (int k = 0; k < WORDS; k++) new_words[k] = 32'h0501_0000 | 32'(k);
        do_refill(5, 1, 1'b0);

        // Table of single-cycle CPU accesses to set 5 way 1 (first read lands in the done cycle)
        tbl[0] = '{1, 0, 6'h14, 32'h0,         4'h0, 1, 32'h0501_0005};
        tbl[1] = '{1, 1, 6'h14, 32'hAABB_CCDD, 4'h5, 1, 32'h0501_0005};
        tbl[2] = '{1, 0, 6'h14, 32'h0,         4'h0, 1, 32'h05BB_00DD};
        tbl[3] = '{1, 0, 6'h00, 32'h0,         4'h0, 1, 32'h0501_0000};
        tbl[4] = '{1, 0, 6'h3C, 32'h0,         4'h0, 1, 32'h0501_000F};
        tbl[5] = '{1, 0, 6'h17, 32'h0,         4'h0, 1, 32'h05BB_00DD};
        tbl[6] = '{0, 1, 6'h20, 32'h1122_3344, 4'hA, 0, 32'h0};
        tbl[7] = '{1, 0, 6'h20, 32'h0,         4'h0, 1, 32'h1101_3308};
        for (int t = 0; t < 8; t++) begin
            i_index   = 5'd5;
            i_way     = 1'b1;
            i_offset  = tbl[t].off;
            i_rd_en   = tbl[t].rd;
            i_wr_en   = tbl[t].wr;
            i_wr_data = tbl[t].wd;
            i_wr_be   = tbl[t].be;
            step();
            i_rd_en = 1'b0;
            i_wr_en = 1'b0;
            chk($sformatf("tbl%0d_valid", t), o_rd_valid, tbl[t].ev);
            if (tbl[t].ev) chk($sformatf("tbl%0d_data", t), o_rd_data, tbl[t].ed);
            if (tbl[t].wr) model_write(5, 1, tbl[t].off, tbl[t].wd, tbl[t].be);
        end

        // Evict with L2 stalling the first 3 cycles
        do_evict(5, 1, 3, 1'b0, 1'b0, 1'b0);
        chk("evict_beat1_word5", cap[1][63:32], 32'h05BB_00DD);

        // Both starts at once, CPU write and stray refill beat during EVICT
        do_evict(5, 1, 1, 1'b0, 1'b1, 1'b1);
        cpu_op(1, 0, 5, 1, 6'h08, 32'h0, 4'h0);
        chk("prio_wr_blocked", o_rd_data, 32'h0501_0002);
        cpu_op(1, 0, 5, 1, 6'h0C, 32'h0, 4'h0);
        chk("prio_refill_ignored", o_rd_data, 32'h0501_0003);

        // Reset after two accepted refill beats
        for (int k = 0; k < WORDS; k++) new_words[k] = $urandom;
        i_index        = 5'd6;
        i_way          = 1'b0;
        i_refill_start = 1'b1;
        step();
        i_refill_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            i_refill_valid = 1'b1;
            i_refill_data  = nw_beat(b);
            step();
        end
        i_refill_valid = 1'b0;
        chk("mid_refill_ready", o_refill_ready, 1'b1);
        rst = 1'b1;
        step();
        chk("mrst_rd_data", o_rd_data, 32'h0);
        chk("mrst_rd_valid", o_rd_valid, 1'b0);
        chk("mrst_refill_ready", o_refill_ready, 1'b0);
        chk("mrst_refill_done", o_refill_done, 1'b0);
        chk("mrst_evict_valid", o_evict_valid, 1'b0);
        chk("mrst_evict_data", o_evict_data, 128'h0);
        chk("mrst_evict_done", o_evict_done, 1'b0);
        chk("mrst_busy", o_busy, 1'b0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mrst_no_done", o_refill_done, 1'b0);
            chk("mrst_idle", o_busy, 1'b0);
        end
        for (int k = 0; k < 2 * WPB; k++) m_word[6][0][k] = new_words[k];
        cpu_op(1, 0, 6, 0, 6'h04, 32'h0, 4'h0);
        cpu_op(1, 0, 6, 0, 6'h18, 32'h0, 4'h0);

        // Randomized traffic against the model on fully written lines
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                for (int k = 0; k < WORDS; k++) new_words[k] = $urandom;
                do_refill(s, w, 1'b1);
            end
        end
        for (int n = 0; n < 250; n++) begin
            int op;
            int s;
            int w;
            op = $urandom_range(0, 9);
            s  = $urandom_range(0, 3);
            w  = $urandom_range(0, 1);
            if (op < 6) begin
                cpu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, w,
                       6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
            end else if (op < 8) begin
                for (int k = 0; k < WORDS; k++) new_words[k] = $urandom;
                do_refill(s, w, 1'b1);
            end else begin
                do_evict(s, w, $urandom_range(0, 2), 1'b1, op == 9, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
